edge_detect: RTL and testbench

Single-bit edge detector producing registered, one-clock-wide pulses on rising and falling transitions of an input level. It turns level signals, such as interrupt request lines or status bits, into edge events for downstream interrupt logic. It sits in the `clk` domain. It can optionally synchronize an asynchronous input before detection.

---
 rtl/edge_detect_pkg.sv | 31 +++
 rtl/edge_sync.sv | 40 ++++
 rtl/edge_detect.sv | 82 ++++++++
 tb/tb_edge_detect.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// ---------------------------------------------------------------------------
// edge_detect_pkg
// Shared types and helpers for the edge detector slice.
//   edge_kind_e       : classification of one sample step of the detector input
//   sync_stages_legal : true for synchronizer depths the detector supports
//   classify_edge     : maps (current, previous) sample pair to an edge kind
// ---------------------------------------------------------------------------
package edge_detect_pkg;

  localparam int SYNC_STAGES_DEFAULT = 0;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_kind_e;

  function automatic bit sync_stages_legal(input int stages);
    return (stages == 0) || (stages == 2) || (stages == 3);
  endfunction

  function automatic edge_kind_e classify_edge(input logic cur, input logic prev);
    if (cur && !prev) begin
      return EDGE_RISE;
    end else if (!cur && prev) begin
      return EDGE_FALL;
    end
    return EDGE_NONE;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// N-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input level
//   q     : synchronized level, STAGES cycles behind d
// ---------------------------------------------------------------------------
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Stage 0 captures the raw input; every later stage copies its predecessor.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Turns a level into registered one-cycle rise/fall pulses, optionally after
// an N-flop synchronizer.
//   clk    : system clock, rising edge active
//   rst_n  : asynchronous active-low reset, clears history and outputs
//   sig    : monitored level
//   r_edge : one-cycle pulse per 0->1 transition of the detector input
//   f_edge : one-cycle pulse per 1->0 transition of the detector input
// ---------------------------------------------------------------------------
module edge_detect
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic r_edge,
  output logic f_edge
);

  logic       s;
  logic       hist_d;
  logic       hist_q;
  logic       rise_d;
  logic       rise_q;
  logic       fall_d;
  logic       fall_q;
  edge_kind_e kind;

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $error("edge_detect: SYNC_STAGES must be 0, 2 or 3");
  end

  if (SYNC_STAGES > 0) begin : g_sync
    edge_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sig),
      .q    (s)
    );
  end else begin : g_direct
    assign s = sig;
  end

  // History resets to 0, so a level already high at reset release counts
  // as a rising edge on the first clock.
  always_comb begin
    kind   = classify_edge(s, hist_q);
    hist_d = s;
    rise_d = (kind == EDGE_RISE);
    fall_d = (kind == EDGE_FALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign r_edge = rise_q;
  assign f_edge = fall_q;

  a_not_both : assert property (@(posedge clk) disable iff (!rst_n)
    !(rise_q && fall_q));

  a_rise_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    rise_q |=> !rise_q);

  a_fall_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    fall_q |=> !fall_q);

endmodule

// File: tb/tb_edge_detect.sv
// ---------------------------------------------------------------------------
// tb_edge_detect
// Directed bench for edge_detect. Two instances share clock and reset: one
// with no synchronizer, one with a 2-flop synchronizer. Stimulus pushes the
// hand-computed expected pulses into a scoreboard keyed by clock cycle; a
// monitor on the falling edge pops and compares whatever is due.
// ---------------------------------------------------------------------------
module tb_edge_detect;

  typedef struct {
    int    due;
    int    sel;
    logic  r;
    logic  f;
    string name;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sig0;
  logic sig2;
  logic r0;
  logic f0;
  logic r2;
  logic f2;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  edge_detect #(.SYNC_STAGES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sig0),
    .r_edge(r0),
    .f_edge(f0)
  );

  edge_detect #(.SYNC_STAGES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sig2),
    .r_edge(r2),
    .f_edge(f2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic act_r, input logic act_f,
                             input logic exp_r, input logic exp_f);
    checks++;
    if ((act_r !== exp_r) || (act_f !== exp_f)) begin
      errors++;
      $display("[TB] FAIL %s: got r_edge=%0b f_edge=%0b, expected r_edge=%0b f_edge=%0b",
               name, act_r, act_f, exp_r, exp_f);
    end
  endtask

  task automatic pushExpect(input int sel, input int delay, input logic r, input logic f,
                            input string name);
    exp_t e;
    e.due  = cyc + delay;
    e.sel  = sel;
    e.r    = r;
    e.f    = f;
    e.name = name;
    sb.push_back(e);
  endtask

  // Drive the unsynchronized instance just after a falling edge; its response
  // is due one clock later.
  task automatic applyStimulus(input logic s, input logic er, input logic ef,
                               input string name);
    @(negedge clk);
    #1;
    sig0 = s;
    pushExpect(0, 1, er, ef, name);
  endtask

  // Drive the synchronized instance; the pulse lands three checks later with
  // quiet cycles before and after it.
  task automatic applySync(input logic s, input logic er, input logic ef,
                           input string name);
    @(negedge clk);
    #1;
    sig2 = s;
    pushExpect(2, 1, 1'b0, 1'b0, {name, "_quiet1"});
    pushExpect(2, 2, 1'b0, 1'b0, {name, "_quiet2"});
    pushExpect(2, 3, er, ef, {name, "_pulse"});
    pushExpect(2, 4, 1'b0, 1'b0, {name, "_after"});
  endtask

  // Monitor: compare every scoreboard entry that falls due on this cycle.
  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        if (sb[i].sel == 0) begin
          checkOutput({"sync0_", sb[i].name}, r0, f0, sb[i].r, sb[i].f);
        end else begin
          checkOutput({"sync2_", sb[i].name}, r2, f2, sb[i].r, sb[i].f);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: entry for cycle %0d never compared, now cycle %0d",
                 sb[i].name, sb[i].due, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, scoreboard holds %0d entries",
             sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sig0   = 1'b0;
    sig2   = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_sync0", r0, f0, 1'b0, 1'b0);
    checkOutput("reset_sync2", r2, f2, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;

    // Idle low after release: no pulses.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, "idle_low");

    // Rising edge then held high.
    applyStimulus(1'b1, 1'b1, 1'b0, "rise");
    applyStimulus(1'b1, 1'b0, 1'b0, "hold_high1");
    applyStimulus(1'b1, 1'b0, 1'b0, "hold_high2");

    // Falling edge then held low.
    applyStimulus(1'b0, 1'b0, 1'b1, "fall");
    applyStimulus(1'b0, 1'b0, 1'b0, "hold_low1");
    applyStimulus(1'b0, 1'b0, 1'b0, "hold_low2");

    // Toggle every cycle: alternating pulses, never both.
    applyStimulus(1'b1, 1'b1, 1'b0, "toggle_r1");
    applyStimulus(1'b0, 1'b0, 1'b1, "toggle_f1");
    applyStimulus(1'b1, 1'b1, 1'b0, "toggle_r2");
    applyStimulus(1'b0, 1'b0, 1'b1, "toggle_f2");
    applyStimulus(1'b0, 1'b0, 1'b0, "toggle_end");

    // Two-stage synchronizer latency, rising then falling.
    applySync(1'b1, 1'b1, 1'b0, "sync_rise");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, "quiet_during_sync");
    applySync(1'b0, 1'b0, 1'b1, "sync_fall");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, "quiet_during_sync");

    // Level high through reset: one rising pulse on the first clock after release.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sig0  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_high_sync0", r0, f0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    pushExpect(0, 1, 1'b1, 1'b0, "release_high_pulse");
    applyStimulus(1'b1, 1'b0, 1'b0, "release_high_hold1");
    applyStimulus(1'b1, 1'b0, 1'b0, "release_high_hold2");

    // Reset in the middle of a rising pulse clears it before the next edge.
    applyStimulus(1'b0, 1'b0, 1'b1, "pre_midreset_fall");
    applyStimulus(1'b0, 1'b0, 1'b0, "pre_midreset_low");
    @(negedge clk);
    #1;
    sig0 = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("midreset_pulse_up", r0, f0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_cleared_sync0", r0, f0, 1'b0, 1'b0);
    checkOutput("midreset_cleared_sync2", r2, f2, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    pushExpect(0, 1, 1'b1, 1'b0, "post_midreset_pulse");
    applyStimulus(1'b1, 1'b0, 1'b0, "post_midreset_hold");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
